systolic_array_param: RTL

SYSTOLIC_ARRAY_PARAM -- requirements
Module: systolic_array_param

---
 rtl/systolic_array_param_if.sv | 29 ++
 rtl/systolic_array_param.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/systolic_array_param_if.sv
// Handshake and data bundle for the weight-stationary systolic array.
// The bench drives the master side; the array implements the slave side.
interface systolic_array_param_if #(
  parameter int N    = 4,
  parameter int DW   = 8,
  parameter int ACCW = 24
);
  logic              sgn;
  logic              w_valid;
  logic              w_ready;
  logic [N*DW-1:0]   w_data;
  logic              a_valid;
  logic              a_ready;
  logic [N*DW-1:0]   a_data;
  logic [N*N-1:0]    err_mult;
  logic [N*N-1:0]    err_mac;
  logic              out_valid;
  logic [N*ACCW-1:0] out_data;

  modport master (
    output sgn, w_valid, w_data, a_valid, a_data, err_mult, err_mac,
    input  w_ready, a_ready, out_valid, out_data
  );

  modport slave (
    input  sgn, w_valid, w_data, a_valid, a_data, err_mult, err_mac,
    output w_ready, a_ready, out_valid, out_data
  );
endinterface

// File: rtl/systolic_array_param.sv
// Weight-stationary NxN systolic array with internal input skew and output deskew.
// Activations flow right, partial sums flow down; results emerge 2N cycles after accept.
module systolic_array_param #(
  parameter int N    = 4,
  parameter int DW   = 8,
  parameter int ACCW = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  systolic_array_param_if.slave bus
);
  localparam int CW  = $clog2(2*N+1);
  localparam int RCW = $clog2(N+1);
  localparam int LAT = 2*N;

  typedef enum logic [1:0] {IDLE, LOAD, READY, DRAIN} state_t;

  state_t            state_reg, state_next;
  logic [RCW-1:0]    row_cnt_reg, row_cnt_next;
  logic              sgn_reg, sgn_next;
  logic [CW-1:0]     inflight_reg;
  logic              w_fire, a_fire;

  logic [DW-1:0]     w_reg    [N][N];
  logic [DW-1:0]     skew_reg [N][N];
  logic [DW-1:0]     act_reg  [N][N];
  logic [ACCW-1:0]   psum_reg [N][N];
  logic [ACCW-1:0]   dsk_reg  [N][N];
  logic [DW-1:0]     act_in   [N][N];
  logic [ACCW-1:0]   mac_next [N][N];
  logic [ACCW-1:0]   col_out  [N];
  logic [LAT-1:0]    vpipe_reg;
  logic              out_valid_reg;
  logic [N*ACCW-1:0] out_data_reg;

  // Ready outputs are forced low while reset is held.
  assign bus.w_ready   = rst_n && (state_reg == IDLE || state_reg == LOAD);
  assign bus.a_ready   = rst_n && (state_reg == READY);
  assign w_fire        = bus.w_valid && bus.w_ready;
  assign a_fire        = bus.a_valid && bus.a_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      row_cnt_reg <= '0;
      sgn_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      row_cnt_reg <= row_cnt_next;
      sgn_reg     <= sgn_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    row_cnt_next = row_cnt_reg;
    sgn_next     = sgn_reg;
    case (state_reg)
      IDLE: begin
        if (w_fire) begin
          sgn_next     = bus.sgn;
          row_cnt_next = RCW'(1);
          state_next   = LOAD;
        end
      end
      LOAD: begin
        if (w_fire) begin
          row_cnt_next = row_cnt_reg + 1'b1;
          if (row_cnt_reg == RCW'(N - 1)) state_next = READY;
        end
      end
      READY: begin
        if (bus.w_valid) state_next = DRAIN;
      end
      DRAIN: begin
        if (inflight_reg == '0) begin
          state_next   = LOAD;
          row_cnt_next = '0;
          sgn_next     = bus.sgn;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg <= '0;
    end else if (a_fire && !out_valid_reg) begin
      inflight_reg <= inflight_reg + 1'b1;
    end else if (!a_fire && out_valid_reg) begin
      inflight_reg <= inflight_reg - 1'b1;
    end
  end

  // Processing elements: the extend-then-multiply keeps the low ACCW bits correct for both signednesses.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      localparam int BIT = gi*N + gj;
      logic [ACCW-1:0] a_ext, w_ext, prod, psum_in;
      if (gj == 0) begin : g_left
        assign act_in[gi][gj] = skew_reg[gi][gi];
      end else begin : g_inner
        assign act_in[gi][gj] = act_reg[gi][gj-1];
      end
      if (gi == 0) begin : g_top
        assign psum_in = '0;
      end else begin : g_below
        assign psum_in = psum_reg[gi-1][gj];
      end
      assign a_ext = {{(ACCW-DW){sgn_reg & act_in[gi][gj][DW-1]}}, act_in[gi][gj]};
      assign w_ext = {{(ACCW-DW){sgn_reg & w_reg[gi][gj][DW-1]}}, w_reg[gi][gj]};
      assign prod  = bus.err_mult[BIT] ? '0 : a_ext * w_ext;
      assign mac_next[gi][gj] = bus.err_mac[BIT] ? psum_in : psum_in + prod;
    end
  end

  // Column c leaves the bottom row c cycles late, so it waits N-1-c more.
  for (genvar gi = 0; gi < N; gi++) begin : g_dsk
    if (gi == N-1) begin : g_last
      assign col_out[gi] = psum_reg[N-1][gi];
    end else begin : g_delay
      assign col_out[gi] = dsk_reg[gi][N-2-gi];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          w_reg[r][c]    <= '0;
          skew_reg[r][c] <= '0;
          act_reg[r][c]  <= '0;
          psum_reg[r][c] <= '0;
          dsk_reg[r][c]  <= '0;
        end
      end
      vpipe_reg <= '0;
    end else begin
      if (w_fire) begin
        for (int c = 0; c < N; c++) w_reg[0][c] <= bus.w_data[c*DW +: DW];
        for (int r = 1; r < N; r++) begin
          for (int c = 0; c < N; c++) w_reg[r][c] <= w_reg[r-1][c];
        end
      end
      for (int r = 0; r < N; r++) begin
        skew_reg[r][0] <= a_fire ? bus.a_data[r*DW +: DW] : '0;
        for (int k = 1; k < N; k++) skew_reg[r][k] <= skew_reg[r][k-1];
        for (int c = 0; c < N; c++) begin
          act_reg[r][c]  <= act_in[r][c];
          psum_reg[r][c] <= mac_next[r][c];
        end
      end
      for (int c = 0; c < N; c++) begin
        dsk_reg[c][0] <= psum_reg[N-1][c];
        for (int k = 1; k < N; k++) dsk_reg[c][k] <= dsk_reg[c][k-1];
      end
      vpipe_reg <= {vpipe_reg[LAT-2:0], a_fire};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= vpipe_reg[LAT-1];
      if (vpipe_reg[LAT-1]) begin
        for (int c = 0; c < N; c++) out_data_reg[c*ACCW +: ACCW] <= col_out[c];
      end
    end
  end
endmodule
